gsm_lpc_frame_sequencer: RTL and testbench

Frame-level controller for the `Gsm_LPC_Analysis` HLS core. It collects 160 input speech samples from a valid/ready stream into a local frame buffer, then starts the core through its ap_ctrl_hs handshake. While the core runs, the block serves the core's `s` and `LARc` memory ports from local storage. When the core finishes, it streams the 8 resulting LAR codes out and rearms for the next frame.

---
 rtl/gsm_lpc_frame_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_gsm_lpc_frame_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gsm_lpc_frame_sequencer.sv
// Frame sequencer for the Gsm_LPC_Analysis core: buffers 160 samples, runs the core, streams 8 LAR codes.
// Optional core run-time statistics are enabled by defining GSM_LPC_SEQ_STATS_EN.
module gsm_lpc_frame_sequencer #(
    parameter int FRAME_LEN = 160,
    parameter int LAR_NUM   = 8,
    parameter int DATA_W    = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              smp_valid,
    output logic              smp_ready,
    input  logic [DATA_W-1:0] smp_data,
    output logic              lar_valid,
    input  logic              lar_ready,
    output logic [DATA_W-1:0] lar_data,
    output logic [2:0]        lar_idx,
    output logic              lar_last,
    output logic              core_start,
    input  logic              core_done,
    input  logic              core_idle,
    input  logic              core_ready,
    input  logic [7:0]        core_s_address0,
    input  logic              core_s_ce0,
    input  logic              core_s_we0,
    input  logic [DATA_W-1:0] core_s_d0,
    output logic [DATA_W-1:0] core_s_q0,
    input  logic [7:0]        core_s_address1,
    input  logic              core_s_ce1,
    input  logic              core_s_we1,
    input  logic [DATA_W-1:0] core_s_d1,
    output logic [DATA_W-1:0] core_s_q1,
    input  logic [2:0]        core_larc_address0,
    input  logic              core_larc_ce0,
    input  logic              core_larc_we0,
    input  logic [DATA_W-1:0] core_larc_d0,
    output logic [DATA_W-1:0] core_larc_q0,
    input  logic [2:0]        core_larc_address1,
    input  logic              core_larc_ce1,
    input  logic              core_larc_we1,
    input  logic [DATA_W-1:0] core_larc_d1,
    output logic [DATA_W-1:0] core_larc_q1,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [31:0]       last_run_cycles
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] LAST_SMP = 8'(FRAME_LEN - 1);
    localparam logic [2:0] LAST_LAR = 3'(LAR_NUM - 1);
    localparam logic [7:0] S_DEPTH  = 8'(FRAME_LEN);

    state_t            state_r, state_s;
    logic [DATA_W-1:0] s_buf_r    [FRAME_LEN];
    logic [DATA_W-1:0] larc_buf_r [LAR_NUM];
    logic [7:0]        wr_ptr_r;
    logic [2:0]        rd_idx_r;
    logic [15:0]       frame_cnt_r;
    logic              smp_beat_s, fill_done_s, lar_beat_s, drain_done_s, core_fin_s;
    logic              s_ok0_s, s_ok1_s, in_run_s;
    logic              unused_s;

    assign unused_s     = core_idle;
    assign smp_beat_s   = smp_valid && (state_r == ST_FILL);
    assign fill_done_s  = smp_beat_s && (wr_ptr_r == LAST_SMP);
    assign lar_beat_s   = lar_ready && (state_r == ST_DRAIN);
    assign drain_done_s = lar_beat_s && (rd_idx_r == LAST_LAR);
    assign in_run_s     = (state_r == ST_START) || (state_r == ST_RUN);
    assign s_ok0_s      = core_s_address0 < S_DEPTH;
    assign s_ok1_s      = core_s_address1 < S_DEPTH;

    assign lar_data  = (state_r == ST_DRAIN) ? larc_buf_r[rd_idx_r] : {DATA_W{1'b0}};
    assign lar_idx   = (state_r == ST_DRAIN) ? rd_idx_r : 3'd0;
    assign lar_last  = (state_r == ST_DRAIN) && (rd_idx_r == LAST_LAR);
    assign frame_cnt = frame_cnt_r;

    // State register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_s    = state_r;
        smp_ready  = 1'b0;
        core_start = 1'b0;
        lar_valid  = 1'b0;
        busy       = 1'b1;
        core_fin_s = 1'b0;
        case (state_r)
            ST_FILL: begin
                smp_ready = 1'b1;
                busy      = 1'b0;
                if (fill_done_s) state_s = ST_START;
                else             state_s = ST_FILL;
            end
            ST_START: begin
                core_start = 1'b1;
                if (core_ready) begin
                    core_fin_s = core_done;
                    state_s    = core_done ? ST_DRAIN : ST_RUN;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_RUN: begin
                if (core_done) begin
                    core_fin_s = 1'b1;
                    state_s    = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                lar_valid = 1'b1;
                if (drain_done_s) state_s = ST_FILL;
                else              state_s = ST_DRAIN;
            end
            default: state_s = ST_FILL;
        endcase
    end

    // Fill pointer, drain index and frame counter
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr_r    <= 8'd0;
            rd_idx_r    <= 3'd0;
            frame_cnt_r <= 16'd0;
        end else begin
            if (fill_done_s)     wr_ptr_r <= 8'd0;
            else if (smp_beat_s) wr_ptr_r <= wr_ptr_r + 8'd1;
            if (core_fin_s)      rd_idx_r <= 3'd0;
            else if (lar_beat_s) rd_idx_r <= rd_idx_r + 3'd1;
            if (drain_done_s)    frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    // Sample buffer writes; core port 1 is applied last so it wins on collisions
    always_ff @(posedge ap_clk) begin
        if (smp_beat_s) s_buf_r[wr_ptr_r] <= smp_data;
        if (core_s_ce0 && core_s_we0 && s_ok0_s) s_buf_r[core_s_address0] <= core_s_d0;
        if (core_s_ce1 && core_s_we1 && s_ok1_s) s_buf_r[core_s_address1] <= core_s_d1;
    end

    // Sample buffer read-first registered read data, zero outside the frame
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            core_s_q0 <= {DATA_W{1'b0}};
            core_s_q1 <= {DATA_W{1'b0}};
        end else begin
            if (core_s_ce0 && !core_s_we0) core_s_q0 <= s_ok0_s ? s_buf_r[core_s_address0] : {DATA_W{1'b0}};
            if (core_s_ce1 && !core_s_we1) core_s_q1 <= s_ok1_s ? s_buf_r[core_s_address1] : {DATA_W{1'b0}};
        end
    end

    // LAR buffer: cleared at reset and when a frame completes filling
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < LAR_NUM; i++) larc_buf_r[i] <= {DATA_W{1'b0}};
        end else begin
            if (fill_done_s) begin
                for (int i = 0; i < LAR_NUM; i++) larc_buf_r[i] <= {DATA_W{1'b0}};
            end
            if (core_larc_ce0 && core_larc_we0) larc_buf_r[core_larc_address0] <= core_larc_d0;
            if (core_larc_ce1 && core_larc_we1) larc_buf_r[core_larc_address1] <= core_larc_d1;
        end
    end

    // LAR buffer read-first registered read data
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            core_larc_q0 <= {DATA_W{1'b0}};
            core_larc_q1 <= {DATA_W{1'b0}};
        end else begin
            if (core_larc_ce0 && !core_larc_we0) core_larc_q0 <= larc_buf_r[core_larc_address0];
            if (core_larc_ce1 && !core_larc_we1) core_larc_q1 <= larc_buf_r[core_larc_address1];
        end
    end

`ifdef GSM_LPC_SEQ_STATS_EN
    logic [31:0] run_cnt_r, last_run_r;

    // Saturating core run-time counter, captured including the done cycle
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            run_cnt_r  <= 32'd0;
            last_run_r <= 32'd0;
        end else begin
            if (fill_done_s)
                run_cnt_r <= 32'd0;
            else if (in_run_s && (run_cnt_r != 32'hFFFF_FFFF))
                run_cnt_r <= run_cnt_r + 32'd1;
            if (core_fin_s)
                last_run_r <= (run_cnt_r == 32'hFFFF_FFFF) ? run_cnt_r : run_cnt_r + 32'd1;
        end
    end

    assign last_run_cycles = last_run_r;
`else
    logic unused_run_s;
    assign unused_run_s    = in_run_s;
    assign last_run_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_gsm_lpc_frame_sequencer.sv
// Directed self-checking bench for gsm_lpc_frame_sequencer; a scripted core model drives the memory ports.
module tb_gsm_lpc_frame_sequencer;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        smp_valid, smp_ready;
    logic [15:0] smp_data;
    logic        lar_valid, lar_ready, lar_last;
    logic [15:0] lar_data;
    logic [2:0]  lar_idx;
    logic        core_start, core_done, core_idle, core_ready;
    logic [7:0]  s_a0, s_a1;
    logic        s_ce0, s_we0, s_ce1, s_we1;
    logic [15:0] s_d0, s_d1, s_q0, s_q1;
    logic [2:0]  l_a0, l_a1;
    logic        l_ce0, l_we0, l_ce1, l_we1;
    logic [15:0] l_d0, l_d1, l_q0, l_q1;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [31:0] last_run_cycles;

    int errors = 0;
    int checks = 0;
    int run_n  = 0;

    gsm_lpc_frame_sequencer dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
        .lar_valid(lar_valid), .lar_ready(lar_ready), .lar_data(lar_data),
        .lar_idx(lar_idx), .lar_last(lar_last),
        .core_start(core_start), .core_done(core_done), .core_idle(core_idle), .core_ready(core_ready),
        .core_s_address0(s_a0), .core_s_ce0(s_ce0), .core_s_we0(s_we0), .core_s_d0(s_d0), .core_s_q0(s_q0),
        .core_s_address1(s_a1), .core_s_ce1(s_ce1), .core_s_we1(s_we1), .core_s_d1(s_d1), .core_s_q1(s_q1),
        .core_larc_address0(l_a0), .core_larc_ce0(l_ce0), .core_larc_we0(l_we0), .core_larc_d0(l_d0), .core_larc_q0(l_q0),
        .core_larc_address1(l_a1), .core_larc_ce1(l_ce1), .core_larc_we1(l_we1), .core_larc_d1(l_d1), .core_larc_q1(l_q1),
        .busy(busy), .frame_cnt(frame_cnt), .last_run_cycles(last_run_cycles)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic logic [31:0] exp_run(input int n);
`ifdef GSM_LPC_SEQ_STATS_EN
        return 32'(n);
`else
        return 32'd0 + 32'(n - n);
`endif
    endfunction

    task automatic send_frame(input logic [15:0] base);
        smp_valid = 1'b1;
        for (int i = 0; i < 160; i++) begin
            smp_data = base + 16'(i);
            if (i == 159) chk("ready_on_last_sample", 32'(smp_ready), 32'd1);
            tick();
        end
        smp_valid = 1'b0;
        smp_data  = 16'd0;
        chk("ready_drop", 32'(smp_ready), 32'd0);
        chk("start_high", 32'(core_start), 32'd1);
        chk("busy_start", 32'(busy), 32'd1);
    endtask

    initial begin
        ap_rst = 1'b1;
        smp_valid = 1'b0; smp_data = 16'd0; lar_ready = 1'b0;
        core_done = 1'b0; core_idle = 1'b1; core_ready = 1'b0;
        s_a0 = 8'd0; s_a1 = 8'd0; s_ce0 = 1'b0; s_ce1 = 1'b0; s_we0 = 1'b0; s_we1 = 1'b0;
        s_d0 = 16'd0; s_d1 = 16'd0;
        l_a0 = 3'd0; l_a1 = 3'd0; l_ce0 = 1'b0; l_ce1 = 1'b0; l_we0 = 1'b0; l_we1 = 1'b0;
        l_d0 = 16'd0; l_d1 = 16'd0;
        repeat (3) tick();
        chk("rst_smp_ready", 32'(smp_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_lar_valid", 32'(lar_valid), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_last_run", last_run_cycles, 32'd0);
        chk("rst_s_q0", 32'(s_q0), 32'd0);
        chk("rst_larc_q1", 32'(l_q1), 32'd0);
        ap_rst = 1'b0;
        tick();

        // Frame 1: samples 0..159, scripted core
        send_frame(16'h0000);
        core_ready = 1'b1; tick(); core_ready = 1'b0; run_n = 1;
        core_idle = 1'b0;
        chk("run_start_low", 32'(core_start), 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
        s_ce0 = 1'b1; s_a0 = 8'd0; s_ce1 = 1'b1; s_a1 = 8'd159;
        tick(); run_n++;
        chk("s_q0_addr0", 32'(s_q0), 32'h0000);
        chk("s_q1_addr159", 32'(s_q1), 32'h009F);
        s_a0 = 8'd200; s_ce1 = 1'b0; s_a1 = 8'd3;
        tick(); run_n++;
        chk("s_oob_read", 32'(s_q0), 32'h0000);
        chk("s_q1_hold", 32'(s_q1), 32'h009F);
        s_we0 = 1'b1; s_d0 = 16'hDEAD;
        tick(); run_n++;
        s_we0 = 1'b0;
        tick(); run_n++;
        chk("s_oob_write_ignored", 32'(s_q0), 32'h0000);
        s_we0 = 1'b1; s_a0 = 8'd5; s_d0 = 16'hAAAA;
        s_ce1 = 1'b1; s_we1 = 1'b1; s_a1 = 8'd5; s_d1 = 16'h5555;
        tick(); run_n++;
        s_we0 = 1'b0; s_d1 = 16'h1234;
        tick(); run_n++;
        chk("s_dual_write_port1_wins", 32'(s_q0), 32'h5555);
        s_ce1 = 1'b0; s_we1 = 1'b0;
        tick(); run_n++;
        chk("s_read_after_write", 32'(s_q0), 32'h1234);
        s_ce0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            l_ce0 = 1'b1; l_we0 = 1'b1; l_a0 = 3'(k); l_d0 = 16'h1000 + 16'(k);
            tick(); run_n++;
        end
        l_ce0 = 1'b0; l_we0 = 1'b0;
        l_ce1 = 1'b1; l_a1 = 3'd3;
        tick(); run_n++;
        chk("larc_q1_addr3", 32'(l_q1), 32'h1003);
        l_ce1 = 1'b0;
        while (run_n < 49) begin
            tick(); run_n++;
        end
        core_done = 1'b1; tick(); run_n++; core_done = 1'b0;
        core_idle = 1'b1;
        chk("drain_valid", 32'(lar_valid), 32'd1);
        chk("drain_first_idx", 32'(lar_idx), 32'd0);
        chk("last_run_f1", last_run_cycles, exp_run(50));
        for (int j = 0; j < 16; j++) begin
            lar_ready = (j % 2 == 1);
            chk("lar_valid_beat", 32'(lar_valid), 32'd1);
            chk("lar_data_beat", 32'(lar_data), 32'h1000 + 32'(j / 2));
            chk("lar_idx_beat", 32'(lar_idx), 32'(j / 2));
            chk("lar_last_beat", 32'(lar_last), (j / 2 == 7) ? 32'd1 : 32'd0);
            tick();
        end
        lar_ready = 1'b0;
        chk("f1_smp_ready_back", 32'(smp_ready), 32'd1);
        chk("f1_lar_valid_off", 32'(lar_valid), 32'd0);
        chk("f1_busy_off", 32'(busy), 32'd0);
        chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);

        // Frame 2: core_ready and core_done on the first start cycle
        send_frame(16'h0100);
        core_ready = 1'b1; core_done = 1'b1;
        tick();
        core_ready = 1'b0; core_done = 1'b0;
        chk("f2_drain_next", 32'(lar_valid), 32'd1);
        chk("f2_idx0", 32'(lar_idx), 32'd0);
        chk("f2_larc_cleared", 32'(lar_data), 32'h0000);
        chk("last_run_f2", last_run_cycles, exp_run(1));
        s_ce0 = 1'b1; s_a0 = 8'd5;
        tick();
        s_ce0 = 1'b0;
        chk("f2_s5_new_frame", 32'(s_q0), 32'h0105);
        lar_ready = 1'b1;
        repeat (8) tick();
        lar_ready = 1'b0;
        chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("f2_smp_ready", 32'(smp_ready), 32'd1);

        // Frame 3: reset in RUN discards everything
        send_frame(16'h0200);
        core_ready = 1'b1; tick(); core_ready = 1'b0;
        repeat (78) tick();
        s_ce0 = 1'b1; s_a0 = 8'd1;
        tick();
        s_ce0 = 1'b0;
        chk("f3_s1", 32'(s_q0), 32'h0201);
        #2;
        ap_rst = 1'b1;
        #1;
        chk("arst_smp_ready", 32'(smp_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_core_start", 32'(core_start), 32'd0);
        chk("arst_lar_valid", 32'(lar_valid), 32'd0);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("arst_s_q0", 32'(s_q0), 32'd0);
        chk("arst_last_run", last_run_cycles, 32'd0);
        tick();
        ap_rst = 1'b0;
        tick();

        // Frame 4: normal frame after reset
        send_frame(16'h0300);
        core_ready = 1'b1; tick(); core_ready = 1'b0;
        repeat (5) tick();
        core_done = 1'b1; tick(); core_done = 1'b0;
        chk("f4_drain", 32'(lar_valid), 32'd1);
        chk("last_run_f4", last_run_cycles, exp_run(7));
        lar_ready = 1'b1;
        repeat (8) tick();
        lar_ready = 1'b0;
        chk("f4_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("f4_smp_ready", 32'(smp_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
